// File: rtl/dmem_rsp_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_rsp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} rsp_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  BE_ALL     = 4'b1111;
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core's load/store port and the responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// DEPTH x 32 backing store: synchronous byte-enable write, asynchronous read.
module dmem_bank
  import dmem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with WAIT_CYCLES wait states.
// Optional range checking is enabled with the DMEM_RSP_ERR_EN macro.
module dmem_responder
  import dmem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  rsp_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;

  logic              accept;
  logic              commit;
  logic              cur_we;
  logic              cur_err;
  logic [ADDR_W-1:0] cur_idx;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_be;
  logic [31:0]       rd_word;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^bus.req_addr[1:0];

`ifdef DMEM_RSP_ERR_EN
  logic err_q;
  logic rsp_err_q;
  logic req_err;

  assign req_err     = |bus.req_addr[31:ADDR_W+2];
  assign cur_err     = (state == IDLE) ? req_err : err_q;
  assign bus.rsp_err = rsp_err_q;
`else
  logic unused_addr_msb;

  assign unused_addr_msb = ^bus.req_addr[31:ADDR_W+2];
  assign cur_err         = 1'b0;
  assign bus.rsp_err     = 1'b0;
`endif

  // With zero wait states the commit happens on the accept edge itself, so the
  // bank must see the live request rather than the not-yet-latched copy.
  always_comb begin
    accept = (state == IDLE) && req_ready_q && bus.req_valid;
    commit = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == '0));
    if (state == IDLE) begin
      cur_we    = bus.req_we;
      cur_idx   = bus.req_addr[ADDR_W+1:2];
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
    end else begin
      cur_we    = we_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef DMEM_RSP_ERR_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q        <= bus.req_we;
            idx_q       <= bus.req_addr[ADDR_W+1:2];
            wdata_q     <= bus.req_wdata;
            be_q        <= bus.req_be;
`ifdef DMEM_RSP_ERR_EN
            err_q       <= req_err;
`endif
            req_ready_q <= 1'b0;
            cnt         <= CNT_INIT;
            state       <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - CNT_W'(1);
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef DMEM_RSP_ERR_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      if (commit) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= (cur_we || cur_err) ? '0 : rd_word;
`ifdef DMEM_RSP_ERR_EN
        rsp_err_q   <= cur_err;
`endif
      end
    end
  end

  dmem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk   (clk),
    .we    (commit && cur_we && !cur_err),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (rd_word)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: a WAIT_CYCLES=2 responder for functional cases, a WAIT_CYCLES=0 one for streaming.
module tb_dmem_responder;
  import dmem_rsp_pkg::*;

  localparam int unsigned W2    = 2;
  localparam int          LIMIT = 50;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [32:0] sb  [$];
  logic [32:0] sb0 [$];

  dmem_responder_if b ();
  dmem_responder_if z ();

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transaction on the WAIT_CYCLES=2 responder; hold = cycles of rsp backpressure.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                      input int hold);
    int          n;
    logic [32:0] e;
    sb.push_back({exp_err, exp_rdata});
    @(negedge clk);
    b.req_valid = 1'b1;
    b.req_we    = we;
    b.req_addr  = addr;
    b.req_wdata = wdata;
    b.req_be    = be;
    n = 0;
    while (!b.req_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < LIMIT), 32'd1);
    @(negedge clk);
    b.req_valid = 1'b0;
    n = 1;
    while (!b.rsp_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(W2 + 1));
    e = (sb.size() > 0) ? sb.pop_front() : 33'h1_DEADDEAD;
    check("rdata", b.rsp_rdata, e[31:0]);
    check("err", 32'(b.rsp_err), 32'(e[32]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(b.rsp_valid), 32'd1);
      check("bp_rdata", b.rsp_rdata, e[31:0]);
      check("bp_err", 32'(b.rsp_err), 32'(e[32]));
      check("bp_ready", 32'(b.req_ready), 32'd0);
    end
    b.rsp_ready = 1'b1;
    @(negedge clk);
    b.rsp_ready = 1'b0;
    check("retire_valid", 32'(b.rsp_valid), 32'd0);
    check("retire_ready", 32'(b.req_ready), 32'd1);
    check("retire_rdata", b.rsp_rdata, 32'd0);
  endtask

  logic        st_we   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] st_addr [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0, 32'h4};
  logic [31:0] st_data [6] = '{32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] st_exp  [6] = '{32'h0, 32'h0, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0A0A0A0A, 32'h0B0B0B0B};

  initial begin
    int          k;
    int          cyc;
    int          acc_cyc;
    int          last_acc;
    int          nrsp;
    logic        adv;
    logic [32:0] e;

    reset = 1'b1;
    b.req_valid = 1'b0; b.req_we = 1'b0; b.req_addr = '0; b.req_wdata = '0;
    b.req_be = '0; b.rsp_ready = 1'b0;
    z.req_valid = 1'b0; z.req_we = 1'b0; z.req_addr = '0; z.req_wdata = '0;
    z.req_be = '0; z.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", 32'(b.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(b.rsp_valid), 32'd0);
    check("rst_rsp_rdata", b.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(b.rsp_err), 32'd0);

    xact(1'b1, 32'd32, 32'h04097016, BE_ALL, 32'h0, 1'b0, 0);
    xact(1'b0, 32'd32, 32'h0, 4'b0000, 32'h04097016, 1'b0, 0);

    xact(1'b1, 32'h40, 32'hAABBCCDD, BE_ALL, 32'h0, 1'b0, 0);
    xact(1'b1, 32'h40, 32'h00001100, 4'b0010, 32'h0, 1'b0, 0);
    xact(1'b0, 32'h43, 32'h0, 4'b0000, 32'hAABB11DD, 1'b0, 4);

    xact(1'b1, 32'd32, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 0);
    xact(1'b0, 32'd32, 32'h0, 4'b0000, 32'h04097016, 1'b0, 0);

    // Reset during WAIT of a store: the store must be abandoned.
    xact(1'b1, 32'd8, 32'h11111111, BE_ALL, 32'h0, 1'b0, 0);
    @(negedge clk);
    b.req_valid = 1'b1; b.req_we = 1'b1; b.req_addr = 32'd8;
    b.req_wdata = 32'hDEADBEEF; b.req_be = BE_ALL;
    @(negedge clk);
    b.req_valid = 1'b0;
    check("pre_rst_ready", 32'(b.req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_valid", 32'(b.rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(b.req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("post_rst_valid", 32'(b.rsp_valid), 32'd0);
    xact(1'b0, 32'd8, 32'h0, 4'b0000, 32'h11111111, 1'b0, 0);

    xact(1'b1, 32'h0, 32'h12345678, BE_ALL, 32'h0, 1'b0, 0);
`ifdef DMEM_RSP_ERR_EN
    xact(1'b1, 32'h100, 32'hCAFEF00D, BE_ALL, 32'h0, 1'b1, 0);
    xact(1'b0, 32'h0, 32'h0, 4'b0000, 32'h12345678, 1'b0, 0);
`else
    xact(1'b1, 32'h100, 32'hCAFEF00D, BE_ALL, 32'h0, 1'b0, 0);
    xact(1'b0, 32'h0, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 0);
`endif

    // Zero-wait streaming with rsp_ready held high.
    @(negedge clk);
    k = 0; cyc = 0; acc_cyc = 0; last_acc = -1; nrsp = 0; adv = 1'b0;
    z.rsp_ready = 1'b1;
    z.req_valid = 1'b1;
    z.req_we    = st_we[0];
    z.req_addr  = st_addr[0];
    z.req_wdata = st_data[0];
    z.req_be    = BE_ALL;
    while (nrsp < 6 && cyc < LIMIT) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (adv) begin
        adv = 1'b0;
        k++;
        if (k < 6) begin
          z.req_we    = st_we[k];
          z.req_addr  = st_addr[k];
          z.req_wdata = st_data[k];
        end else begin
          z.req_valid = 1'b0;
        end
      end
      if (z.rsp_valid) begin
        e = (sb0.size() > 0) ? sb0.pop_front() : 33'h1_DEADDEAD;
        check("zw_rdata", z.rsp_rdata, e[31:0]);
        check("zw_lat", 32'(cyc - acc_cyc), 32'd1);
        nrsp++;
      end
      if (z.req_ready && z.req_valid) begin
        if (last_acc >= 0) check("zw_spacing", 32'(cyc - last_acc), 32'd2);
        last_acc = cyc;
        acc_cyc  = cyc;
        sb0.push_back({1'b0, st_exp[k]});
        adv = 1'b1;
      end
    end
    z.req_valid = 1'b0;
    check("zw_count", 32'(nrsp), 32'd6);
    @(negedge clk);
    z.rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's load/store port: the memory-side end of the processor's data access interface.
- Accepts one request at a time via a valid/ready handshake and applies a configurable number of wait states.
- Performs the byte-lane write or the full-word read, then returns a registered response under a valid/ready handshake.
- Provides the multi-cycle memory the core's stall logic is built against; replaces the zero-latency data RAM for latency testing.

Parameters:
- DEPTH, 64, number of 32-bit words in the backing store; power of two.
- WAIT_CYCLES, 2, wait-state cycles between request accept and response; 0 allowed.
- ADDR_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [1:0] are ignored.
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; lane i is bits [8i+7:8i]; ignored on loads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load data; 0 for store responses.
- rsp_err  output  1  access error; see Optional Feature.

Behaviour:
- Reset is synchronous and active-high on clk.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Accept on the edge where req_valid & req_ready: latch we, word index req_addr[ADDR_W+1:2], wdata, be.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT:
  - req_ready = 0.
  - Counter loads WAIT_CYCLES-1 on accept and decrements each cycle.
  - Leave for RESP on the edge where the counter equals 0.
  - The total time spent in WAIT is exactly WAIT_CYCLES cycles.
- Commit edge (the edge entering RESP):
  - Store: write the enabled byte lanes only.
  - Load: register the full word into rsp_rdata.
  - Set rsp_valid = 1.
- RESP:
  - req_ready = 0.
  - rsp_valid, rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid -> 0, rsp_rdata -> 0, rsp_err -> 0, state -> IDLE.
- Latency: rsp_valid first high WAIT_CYCLES+1 cycles after the accept cycle.
- Throughput: with rsp_ready held high, the minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- No overlap: a request is never accepted during WAIT or RESP, even if the response is retired in the same cycle.
- Ordering:
  - A load after a store to the same word returns the merged post-store word.
  - A store with req_be = 0 completes with a response and modifies nothing.
- Address range: without the macro, the upper address bits are ignored and addresses wrap modulo DEPTH*4.
- Reset mid-operation: an accepted store that has not yet reached its commit edge is abandoned and memory is unchanged. Any pending response is dropped.

Optional Feature:
- Macro: DMEM_RSP_ERR_EN.
- With DMEM_RSP_ERR_EN defined:
  - A request with req_addr >= DEPTH*4 is an error.
  - An error request follows the same timing as a normal request.
  - At the commit edge: no write, rsp_rdata = 0, rsp_err = 1 alongside rsp_valid.
- Without DMEM_RSP_ERR_EN: rsp_err is tied to 0, addresses wrap, and no range logic is instantiated.

Decomposition:
- Package dmem_rsp_pkg contains:
  - typedef enum logic [1:0] rsp_state_t {IDLE, WAIT, RESP};
  - localparams WORD_BYTES = 4 and BE_ALL = 4'b1111.
- Sub-module dmem_bank: DEPTH x 32 array with a synchronous byte-enable write port and an asynchronous read port. The FSM and counter stay in dmem_responder.

Test Plan:
- Store then load (WAIT_CYCLES=2): store 0x04097016 to addr 32 with be 1111 -> rsp_valid in the 3rd cycle after accept with rdata 0. Then load addr 32 -> rsp_rdata 0x04097016.
- Byte enables: word at 0x40 holds 0xAABBCCDD; store 0x00001100 with be 0010 -> a subsequent load of 0x40 returns 0xAABB11DD.
- Response backpressure: hold rsp_ready low for 4 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err are stable and req_ready stays 0. Raise rsp_ready -> IDLE and req_ready 1 on the next cycle.
- Reset mid-operation: addr 8 holds 0x11111111; assert reset during WAIT of a store 0xDEADBEEF to addr 8 -> rsp_valid 0 and req_ready 1 after reset. A later load of addr 8 returns 0x11111111.
- Range error (DEPTH=64):
  - With DMEM_RSP_ERR_EN: store to 0x100 -> rsp_err 1, rdata 0, and word 0 is unchanged.
  - Without the macro: the same store writes word 0, and rsp_err is 0.
- Zero-wait back-to-back (WAIT_CYCLES=0, rsp_ready=1): continuous loads of addr 0 and addr 4 -> each rsp_valid appears 1 cycle after its accept, and accepts are spaced exactly 2 cycles apart.
